// File: rtl/esm_pkg.sv
// Shared definitions for the ESM front end.
// Holds the supported opcodes, the bubble word and the control decoder.
package esm_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_CST   = 7'b1010011;

    // All-zero word is the bubble the ESM treats as "no instruction"
    localparam logic [31:0] NOP = 32'h0000_0000;

    // Returns {legal, RegWrite, ALUSrc} for a 7-bit opcode
    function automatic logic [2:0] decode_ctrl(input logic [6:0] opcode);
        case (opcode)
            OP_R:     return 3'b110;
            OP_I:     return 3'b111;
            OP_LOAD:  return 3'b111;
            OP_STORE: return 3'b101;
            OP_CST:   return 3'b100;
            default:  return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with occupancy count.
// The caller guarantees push only when not full and pop only when not empty.
// Head word is read combinationally so the issue stage can register it directly.
module instr_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [DEPTH-1:0] wr_en;

    // One write strobe per entry, selected by the write pointer
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_reg == AW'(gi));
        end
    endgenerate

    // Storage array: no reset, contents are don't-care until written
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                mem_reg[i] <= wdata;
            end
        end
    end

    // Pointers wrap naturally; count disambiguates full from empty
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rdata = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/instr_issue_queue.sv
// Issue stage ahead of the ESM scheduler: buffers fetched words, decodes
// RegWrite/ALUSrc and presents one instruction or bubble per cycle.
// Illegal opcodes are issued as bubbles and counted (saturating).
module instr_issue_queue
    import esm_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int XLEN  = 32,
    parameter  int ERRW  = 8,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic            stall,
    output logic [XLEN-1:0] Instr_in,
    output logic            ALUSrc,
    output logic            RegWrite,
    output logic [CW-1:0]   count,
    output logic [ERRW-1:0] illegal_cnt
);

    logic [XLEN-1:0] head;
    logic [CW-1:0]   fifo_count;
    logic            fifo_push;
    logic            fifo_pop;
    logic [2:0]      head_ctrl;

    logic [XLEN-1:0] instr_reg;
    logic            alu_src_reg;
    logic            reg_write_reg;
    logic [ERRW-1:0] illegal_cnt_reg;

    // Ready depends only on registered occupancy, never on a same-cycle pop
    assign in_ready  = (fifo_count != CW'(DEPTH));
    // Zero words are accepted from fetch but silently dropped
    assign fifo_push = in_valid && in_ready && (in_instr != XLEN'(NOP));
    assign fifo_pop  = !stall && (fifo_count != '0);
    assign head_ctrl = decode_ctrl(head[6:0]);

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (in_instr),
        .rdata (head),
        .count (fifo_count)
    );

    // Output registers: hold on stall, else load decoded head or a bubble
    always_ff @(posedge clk) begin
        if (!rst) begin
            instr_reg       <= XLEN'(NOP);
            alu_src_reg     <= 1'b0;
            reg_write_reg   <= 1'b0;
            illegal_cnt_reg <= '0;
        end else if (!stall) begin
            if (fifo_pop && head_ctrl[2]) begin
                instr_reg     <= head;
                reg_write_reg <= head_ctrl[1];
                alu_src_reg   <= head_ctrl[0];
            end else begin
                instr_reg     <= XLEN'(NOP);
                reg_write_reg <= 1'b0;
                alu_src_reg   <= 1'b0;
            end
            if (fifo_pop && !head_ctrl[2] && (illegal_cnt_reg != '1)) begin
                illegal_cnt_reg <= illegal_cnt_reg + 1'b1;
            end
        end
    end

    assign Instr_in    = instr_reg;
    assign ALUSrc      = alu_src_reg;
    assign RegWrite    = reg_write_reg;
    assign count       = fifo_count;
    assign illegal_cnt = illegal_cnt_reg;

endmodule

// File: tb/tb_instr_issue_queue.sv
// Scoreboard bench for instr_issue_queue: the driver updates a queue-based
// reference model each cycle and pushes the expected post-edge state; a
// separate monitor pops one expectation per clock edge and compares.
module tb_instr_issue_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int ERRW  = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int ILL_MAX = (1 << ERRW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [XLEN-1:0] in_instr = '0;
    logic            stall = 1'b0;
    logic [XLEN-1:0] Instr_in;
    logic            ALUSrc;
    logic            RegWrite;
    logic [CW-1:0]   count;
    logic [ERRW-1:0] illegal_cnt;

    always #5 clk = ~clk;

    instr_issue_queue #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN),
        .ERRW  (ERRW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .stall       (stall),
        .Instr_in    (Instr_in),
        .ALUSrc      (ALUSrc),
        .RegWrite    (RegWrite),
        .count       (count),
        .illegal_cnt (illegal_cnt)
    );

    typedef struct {
        logic [31:0] instr;
        logic        rw;
        logic        as;
        logic        rdy;
        int          cnt;
        int          ill;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_q[$];
    logic [31:0] m_instr = '0;
    logic        m_rw = 1'b0;
    logic        m_as = 1'b0;
    int          m_ill = 0;
    int          total = 0;
    int          bad = 0;
    int          edge_n = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s edge=%0d got=%0h expected=%0h", name, edge_n, got, want);
        end
    endtask

    // Reference decode straight from the opcode table: {legal, RegWrite, ALUSrc}
    function automatic logic [2:0] ref_decode(input logic [31:0] w);
        case (w[6:0])
            7'h33:   return 3'b110;
            7'h13:   return 3'b111;
            7'h03:   return 3'b111;
            7'h23:   return 3'b101;
            7'h53:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Drive one cycle of inputs and predict the state after the next edge
    task automatic step(input logic v, input logic [31:0] w, input logic st, input logic rn);
        logic        ready;
        logic [31:0] head;
        logic [2:0]  d;
        exp_t        e;
        @(negedge clk);
        in_valid = v;
        in_instr = w;
        stall    = st;
        rst      = rn;
        if (!rn) begin
            model_q.delete();
            m_instr = '0; m_rw = 0; m_as = 0; m_ill = 0;
        end else begin
            ready = (model_q.size() < DEPTH);
            if (!st) begin
                if (model_q.size() > 0) begin
                    head = model_q.pop_front();
                    d = ref_decode(head);
                    if (d[2]) begin
                        m_instr = head; m_rw = d[1]; m_as = d[0];
                    end else begin
                        m_instr = '0; m_rw = 0; m_as = 0;
                        if (m_ill < ILL_MAX) m_ill++;
                    end
                end else begin
                    m_instr = '0; m_rw = 0; m_as = 0;
                end
            end
            if (v && ready && w != 0) model_q.push_back(w);
        end
        e.instr = m_instr; e.rw = m_rw; e.as = m_as;
        e.cnt = model_q.size(); e.rdy = (model_q.size() != DEPTH); e.ill = m_ill;
        exp_q.push_back(e);
    endtask

    // Monitor: one expectation per clock edge, sampled 1 time unit after it
    always @(posedge clk) begin
        exp_t e;
        #1;
        edge_n++;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("instr", Instr_in, e.instr);
            check("regwrite", 32'(RegWrite), 32'(e.rw));
            check("alusrc", 32'(ALUSrc), 32'(e.as));
            check("count", 32'(count), e.cnt);
            check("in_ready", 32'(in_ready), 32'(e.rdy));
            check("illegal_cnt", 32'(illegal_cnt), e.ill);
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: return {r[31:7], 7'h33};
            1: return {r[31:7], 7'h13};
            2: return {r[31:7], 7'h03};
            3: return {r[31:7], 7'h23};
            4: return {r[31:7], 7'h53};
            5: return {r[31:7], 7'h7F};
            6: return 32'h0;
            default: return r;
        endcase
    endfunction

    initial begin
        logic acc;
        // Reset and idle
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 1);

        // Back-to-back decode
        step(1, 32'h0010_0093, 0, 1);
        step(1, 32'h0031_01B3, 0, 1);
        step(1, 32'h0010_A023, 0, 1);
        repeat (3) step(0, 0, 0, 1);

        // Fill under stall, then drain; 5th word waits for in_ready
        step(1, 32'h0000_0533, 1, 1);
        step(1, 32'h0040_0593, 1, 1);
        step(1, 32'h0080_2603, 1, 1);
        step(1, 32'h00C0_26A3, 1, 1);
        step(1, 32'h0100_0753, 1, 1);
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = (model_q.size() < DEPTH);
            step(1, 32'h0100_0753, 0, 1);
        end
        check("fifth_accept", 32'(acc), 32'd1);
        repeat (6) step(0, 0, 0, 1);

        // Reach count=3 under stall, then push/pop together across wrap
        step(1, 32'h0010_0113, 1, 1);
        step(1, 32'h0020_0193, 1, 1);
        step(1, 32'h0030_0213, 1, 1);
        for (int i = 0; i < 6; i++) step(1, 32'h0040_0293 + (i << 20), 0, 1);
        repeat (5) step(0, 0, 0, 1);

        // Illegal word, dropped zero, then saturation
        step(1, 32'h0000_007F, 0, 1);
        repeat (2) step(0, 0, 0, 1);
        step(1, 32'h0000_0000, 0, 1);
        step(1, 32'h0000_0000, 1, 1);
        step(0, 0, 0, 1);
        for (int i = 0; i < 260; i++) step(1, {$urandom_range(1, 255), 7'h7F} , 0, 1);
        repeat (3) step(0, 0, 0, 1);

        // Reset mid-operation with count=3 under stall
        step(1, 32'h0000_0533, 1, 1);
        step(1, 32'h0000_05B3, 1, 1);
        step(1, 32'h0000_0633, 1, 1);
        step(0, 0, 1, 0);
        repeat (5) step(0, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 3) != 0), rand_instr(),
                 ($urandom_range(0, 9) < 3), ($urandom_range(0, 199) != 0));
        end
        repeat (8) step(0, 0, 0, 1);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
